// File: rtl/ws2812_pkg.sv
// Shared register map, control/status bit positions and serializer state
// encoding for the WS2812 APB LED controller.
package ws2812_pkg;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_COUNT  = 8'h08;
    localparam logic [7:0] REG_PIXEL  = 8'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_BUSY_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_LATCH = 3'd4
    } ser_state_t;

endpackage

// File: rtl/ws2812_apb_ctrl_if.sv
// APB slave bus bundle for the WS2812 controller; clock and reset stay outside.
// Handshake: an access is psel&penable; the slave answers with pready high for
// exactly one cycle (one wait state), with prdata/pslverr valid in that cycle.
interface ws2812_apb_ctrl_if;

    logic        apb_psel_i;
    logic        apb_penable_i;
    logic        apb_pwrite_i;
    logic [7:0]  apb_paddr_i;
    logic [31:0] apb_pwdata_i;
    logic [31:0] apb_prdata_o;
    logic        apb_pready_o;
    logic        apb_pslverr_o;

    modport slave (
        input  apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i,
        output apb_prdata_o, apb_pready_o, apb_pslverr_o
    );

    modport master (
        output apb_psel_i, apb_penable_i, apb_pwrite_i, apb_paddr_i, apb_pwdata_i,
        input  apb_prdata_o, apb_pready_o, apb_pslverr_o
    );

endinterface

// File: rtl/ws2812_serializer.sv
// WS2812 bit serializer: fetches pixels from the buffer, shifts GRB out MSB
// first as timed high/low pulses, then holds the line low for the latch time.
module ws2812_serializer
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC  = 35,
    parameter int T1H_CYC  = 70,
    parameter int TBIT_CYC = 125,
    parameter int TRST_CYC = 3000
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        start_i,
    input  logic [5:0]  count_i,
    input  logic [23:0] pixel_i,
    output logic [5:0]  pix_idx_o,
    output logic        led_ctl_o,
    output ser_state_t  state_o
);

    localparam int CYC_W = $clog2(TBIT_CYC);
    localparam int LAT_W = (TRST_CYC > 1) ? $clog2(TRST_CYC) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TBIT_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(TBIT_CYC - 2);
    localparam logic [CYC_W-1:0] CYC_T0H  = CYC_W'(T0H_CYC - 1);
    localparam logic [CYC_W-1:0] CYC_T1H  = CYC_W'(T1H_CYC - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRST_CYC - 1);

    ser_state_t        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q;
    logic [LAT_W-1:0]  lat_q;
    logic [4:0]        bit_q;
    logic [5:0]        pix_q;
    logic [5:0]        count_q;
    logic [23:0]       shift_q;
    logic              led_q;
    logic              high_done, bit_done, last_bit, more_pix, load_slot;

    assign high_done = shift_q[23] ? (cyc_q == CYC_T1H) : (cyc_q == CYC_T0H);
    assign bit_done  = (cyc_q == CYC_LAST);
    assign last_bit  = (bit_q == 5'd23);
    assign more_pix  = ((pix_q + 6'd1) < count_q);
    // The next pixel's LOAD cycle replaces the final low cycle of the current bit.
    assign load_slot = last_bit && more_pix && (cyc_q == CYC_LOAD);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_LOAD;
            ST_LOAD:  state_d = (count_q == 6'd0) ? ST_LATCH : ST_HIGH;
            ST_HIGH:  if (high_done) state_d = load_slot ? ST_LOAD : ST_LOW;
            ST_LOW: begin
                if (load_slot)     state_d = ST_LOAD;
                else if (bit_done) state_d = last_bit ? ST_LATCH : ST_HIGH;
            end
            ST_LATCH: if (lat_q == LAT_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cyc_q   <= '0;
            lat_q   <= '0;
            bit_q   <= '0;
            pix_q   <= '0;
            count_q <= '0;
            shift_q <= '0;
            led_q   <= 1'b0;
        end else begin
            led_q <= (state_d == ST_HIGH);
            lat_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        count_q <= count_i;
                        pix_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    shift_q <= pixel_i;
                    bit_q   <= '0;
                    cyc_q   <= '0;
                end
                ST_HIGH, ST_LOW: begin
                    if (state_d == ST_LOAD) pix_q <= pix_q + 6'd1;
                    if (state_q == ST_LOW && state_d == ST_HIGH) begin
                        cyc_q   <= '0;
                        bit_q   <= bit_q + 5'd1;
                        shift_q <= {shift_q[22:0], 1'b0};
                    end else if (!bit_done) begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_LATCH: if (lat_q != LAT_LAST) lat_q <= lat_q + LAT_W'(1);
                default: ;
            endcase
        end
    end

    assign pix_idx_o = pix_q;
    assign led_ctl_o = led_q;
    assign state_o   = state_q;

endmodule

// File: rtl/ws2812_apb_ctrl.sv
// WS2812 LED strip controller: APB register decode and pixel buffer, driving
// the ws2812_serializer that produces the single-wire data stream.
module ws2812_apb_ctrl
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int T0H_CYC  = 35,
    parameter int T1H_CYC  = 70,
    parameter int TBIT_CYC = 125,
    parameter int TRST_CYC = 3000
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    ws2812_apb_ctrl_if.slave apb,
    output logic             led_ctl_o,
    output logic             debug_o
);

    localparam int         IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [5:0] NUM_LEDS_6 = 6'(NUM_LEDS);

    logic [23:0] pix_mem [NUM_LEDS];
    logic [5:0]  count_q;
    logic        pready_q, pslverr_q;
    logic [31:0] prdata_q;
    logic        access, wr_acc, start_req, busy;
    logic        aligned, hit_ctrl, hit_status, hit_count, hit_pixel, addr_ok;
    logic [5:0]  word_idx, pix_addr_idx, ser_idx;
    logic [23:0] ser_pixel;
    logic [31:0] rd_data;
    ser_state_t  ser_state;

    // pready_q masks the second access cycle so each transfer acts only once.
    assign access    = apb.apb_psel_i & apb.apb_penable_i & ~pready_q;
    assign wr_acc    = access & apb.apb_pwrite_i;
    assign start_req = wr_acc & hit_ctrl & apb.apb_pwdata_i[CTRL_START_BIT];
    assign busy      = (ser_state != ST_IDLE);

    always_comb begin
        word_idx     = apb.apb_paddr_i[7:2];
        pix_addr_idx = word_idx - REG_PIXEL[7:2];
        aligned      = (apb.apb_paddr_i[1:0] == 2'b00);
        hit_ctrl     = aligned && (word_idx == REG_CTRL[7:2]);
        hit_status   = aligned && (word_idx == REG_STATUS[7:2]);
        hit_count    = aligned && (word_idx == REG_COUNT[7:2]);
        hit_pixel    = aligned && (word_idx >= REG_PIXEL[7:2]) && (pix_addr_idx < NUM_LEDS_6);
        addr_ok      = hit_ctrl | hit_status | hit_count | hit_pixel;
        rd_data      = '0;
        if (hit_status) rd_data[STATUS_BUSY_BIT] = busy;
        if (hit_count)  rd_data[5:0] = count_q;
        if (hit_pixel)  rd_data[23:0] = pix_mem[pix_addr_idx[IDX_W-1:0]];
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            count_q   <= NUM_LEDS_6;
        end else begin
            pready_q  <= access;
            pslverr_q <= access & ~addr_ok;
            prdata_q  <= (access && !apb.apb_pwrite_i) ? rd_data : '0;
            if (wr_acc && hit_count)
                count_q <= (apb.apb_pwdata_i > 32'(NUM_LEDS)) ? NUM_LEDS_6 : apb.apb_pwdata_i[5:0];
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < NUM_LEDS; i++) pix_mem[i] <= '0;
        end else if (wr_acc && hit_pixel) begin
            pix_mem[pix_addr_idx[IDX_W-1:0]] <= apb.apb_pwdata_i[23:0];
        end
    end

    assign ser_pixel = (ser_idx < NUM_LEDS_6) ? pix_mem[ser_idx[IDX_W-1:0]] : '0;

    ws2812_serializer #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC),
        .TRST_CYC (TRST_CYC)
    ) u_ser (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .start_i   (start_req),
        .count_i   (count_q),
        .pixel_i   (ser_pixel),
        .pix_idx_o (ser_idx),
        .led_ctl_o (led_ctl_o),
        .state_o   (ser_state)
    );

    assign apb.apb_prdata_o  = prdata_q;
    assign apb.apb_pready_o  = pready_q;
    assign apb.apb_pslverr_o = pslverr_q;
    assign debug_o           = busy;

endmodule

// File: tb/tb_ws2812_apb_ctrl.sv
// Self-checking bench for ws2812_apb_ctrl: APB register behaviour plus whole
// frames compared cycle by cycle against a waveform built from pixel values.
module tb_ws2812_apb_ctrl;

    localparam int NUM_LEDS = 4;
    localparam int T0H  = 2;
    localparam int T1H  = 4;
    localparam int TBIT = 6;
    localparam int TRST = 10;
    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_COUNT  = 8'h08;
    localparam logic [7:0] A_PIX    = 8'h10;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic led, debug;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [23:0] model_pix [NUM_LEDS];
    logic [1:0]  exp_q[$];   // per cycle {busy, led}

    ws2812_apb_ctrl_if apb ();

    ws2812_apb_ctrl #(
        .NUM_LEDS (NUM_LEDS),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRST_CYC (TRST)
    ) dut (
        .clk_i     (clk),
        .resetn_i  (resetn),
        .apb       (apb),
        .led_ctl_o (led),
        .debug_o   (debug)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
        int waitc;
        @(posedge clk); #1;
        apb.apb_psel_i = 1'b1; apb.apb_pwrite_i = 1'b1; apb.apb_penable_i = 1'b0;
        apb.apb_paddr_i = addr; apb.apb_pwdata_i = data;
        @(posedge clk); #1;
        apb.apb_penable_i = 1'b1;
        waitc = 0;
        do begin
            @(posedge clk); #1;
            waitc++;
        end while (!apb.apb_pready_o && waitc < 8);
        check("wr_wait_states", 32'(waitc), 32'd1);
        err = apb.apb_pslverr_o;
        apb.apb_psel_i = 1'b0; apb.apb_penable_i = 1'b0; apb.apb_pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
        int waitc;
        @(posedge clk); #1;
        apb.apb_psel_i = 1'b1; apb.apb_pwrite_i = 1'b0; apb.apb_penable_i = 1'b0;
        apb.apb_paddr_i = addr;
        @(posedge clk); #1;
        apb.apb_penable_i = 1'b1;
        waitc = 0;
        do begin
            @(posedge clk); #1;
            waitc++;
        end while (!apb.apb_pready_o && waitc < 8);
        check("rd_wait_states", 32'(waitc), 32'd1);
        data = apb.apb_prdata_o;
        err  = apb.apb_pslverr_o;
        apb.apb_psel_i = 1'b0; apb.apb_penable_i = 1'b0;
        @(posedge clk); #1;
        check("rd_pready_drop", 32'(apb.apb_pready_o), 32'd0);
    endtask

    // Frame timeline starting the cycle after START: one entry cycle, 24 bit
    // periods per pixel MSB first, latch-low time, then idle.
    task automatic build_exp(input int cnt);
        int th;
        exp_q.delete();
        exp_q.push_back(2'b10);
        for (int p = 0; p < cnt; p++) begin
            for (int b = 23; b >= 0; b--) begin
                th = model_pix[p][b] ? T1H : T0H;
                for (int c = 0; c < TBIT; c++) exp_q.push_back({1'b1, (c < th)});
            end
        end
        for (int c = 0; c < TRST; c++) exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
    endtask

    task automatic check_frame(input string tag);
        int n, bad, first;
        logic [1:0] o, e, fo, fe;
        n = exp_q.size(); bad = 0; first = -1; fo = '0; fe = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = {debug, led};
            e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                if (first < 0) begin first = i; fo = o; fe = e; end
            end
        end
        n_assert++;
        assert (bad === 0) else begin
            n_fail++;
            $error("FAIL %s: %0d cycles differ, first at cycle %0d observed busy/led=%b expected %b",
                   tag, bad, first, fo, fe);
        end
    endtask

    task automatic set_pixel(input int p, input logic [31:0] v);
        logic err;
        apb_write(A_PIX + 8'(4 * p), v, err);
        check("pix_wr_err", 32'(err), 32'd0);
        model_pix[p] = v[23:0];
    endtask

    initial begin
        logic        err;
        logic [31:0] rd, v, newv;
        int          cnt;

        apb.apb_psel_i = 1'b0; apb.apb_penable_i = 1'b0; apb.apb_pwrite_i = 1'b0;
        apb.apb_paddr_i = '0; apb.apb_pwdata_i = '0;
        for (int i = 0; i < NUM_LEDS; i++) model_pix[i] = '0;

        // Reset values
        repeat (3) @(posedge clk); #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(debug), 32'd0);
        check("rst_pready", 32'(apb.apb_pready_o), 32'd0);
        check("rst_pslverr", 32'(apb.apb_pslverr_o), 32'd0);
        check("rst_prdata", apb.apb_prdata_o, 32'd0);
        @(negedge clk); resetn = 1'b1;
        apb_read(A_COUNT, rd, err);
        check("rst_count", rd, 32'd4);
        check("rst_count_err", 32'(err), 32'd0);
        for (int i = 0; i < NUM_LEDS; i++) begin
            apb_read(A_PIX + 8'(4 * i), rd, err);
            check("rst_pixel", rd, 32'd0);
        end
        apb_read(A_STATUS, rd, err);
        check("rst_status", rd, 32'd0);

        // Single pixel frame 0x800001
        set_pixel(0, 32'h0080_0001);
        apb_write(A_COUNT, 32'd1, err);
        build_exp(1);
        apb_write(A_CTRL, 32'd1, err);
        check("start_err", 32'(err), 32'd0);
        check_frame("frame_single");
        apb_read(A_CTRL, rd, err);
        check("ctrl_reads_zero", rd, 32'd0);

        // COUNT clamp and decode errors
        apb_write(A_COUNT, 32'd9, err);
        check("count9_err", 32'(err), 32'd0);
        apb_read(A_COUNT, rd, err);
        check("count9_clamp", rd, 32'd4);
        apb_read(8'h0C, rd, err);
        check("rd_0c_err", 32'(err), 32'd1);
        check("rd_0c_data", rd, 32'd0);
        apb_read(8'h11, rd, err);
        check("rd_11_err", 32'(err), 32'd1);
        check("rd_11_data", rd, 32'd0);
        apb_write(8'h20, 32'h00FF_FFFF, err);
        check("wr_pix4_err", 32'(err), 32'd1);
        apb_write(8'h12, 32'h00FF_FFFF, err);
        check("wr_12_err", 32'(err), 32'd1);
        apb_read(A_PIX, rd, err);
        check("pix0_unchanged", rd, 32'h0080_0001);

        // Empty frame: latch only
        apb_write(A_COUNT, 32'd0, err);
        build_exp(0);
        apb_write(A_CTRL, 32'd1, err);
        check_frame("frame_count0");

        // START while busy is ignored; STATUS shows busy
        set_pixel(0, $urandom);
        apb_write(A_COUNT, 32'd1, err);
        build_exp(1);
        apb_write(A_CTRL, 32'd1, err);
        fork
            check_frame("frame_restart");
            begin
                repeat (20) @(posedge clk);
                apb_read(A_STATUS, rd, err);
                check("status_busy", rd, 32'd1);
                apb_write(A_CTRL, 32'd1, err);
                check("start_busy_err", 32'(err), 32'd0);
            end
        join

        // Pixel writes mid-frame: pixel 1 not yet loaded, pixel 0 already loaded
        set_pixel(0, $urandom);
        set_pixel(1, 32'd0);
        apb_write(A_COUNT, 32'd2, err);
        model_pix[1] = 24'hFF_FFFF;
        newv = $urandom;
        build_exp(2);
        apb_write(A_CTRL, 32'd1, err);
        fork
            check_frame("frame_update");
            begin
                repeat (40) @(posedge clk);
                apb_write(A_PIX + 8'd4, 32'h00FF_FFFF, err);
                apb_write(A_PIX, newv, err);
            end
        join
        model_pix[0] = newv[23:0];
        apb_read(A_PIX, rd, err);
        check("pix0_late_write", rd, {8'd0, model_pix[0]});

        // Reset in the middle of a frame
        set_pixel(0, 32'h00FF_FFFF);
        apb_write(A_COUNT, 32'd4, err);
        build_exp(4);
        apb_write(A_CTRL, 32'd1, err);
        repeat (50) @(negedge clk);
        check("mid_led_before_rst", 32'(led), 32'(exp_q[49][0]));
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_led", 32'(led), 32'd0);
        check("mid_rst_busy", 32'(debug), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < NUM_LEDS; i++) model_pix[i] = '0;
        apb_read(A_COUNT, rd, err);
        check("mid_rst_count", rd, 32'd4);
        apb_read(A_PIX, rd, err);
        check("mid_rst_pix0", rd, 32'd0);
        apb_read(A_STATUS, rd, err);
        check("mid_rst_status", rd, 32'd0);
        set_pixel(2, $urandom);
        build_exp(4);
        apb_write(A_CTRL, 32'd1, err);
        check_frame("frame_after_rst");

        // Random COUNT clamping
        for (int r = 0; r < 4; r++) begin
            v = 32'($urandom_range(0, 70));
            apb_write(A_COUNT, v, err);
            apb_read(A_COUNT, rd, err);
            check("count_rand", rd, (v > 32'd4) ? 32'd4 : v);
        end

        // Random frames
        for (int r = 0; r < 4; r++) begin
            cnt = $urandom_range(0, NUM_LEDS);
            for (int p = 0; p < NUM_LEDS; p++) set_pixel(p, $urandom);
            apb_write(A_COUNT, 32'(cnt), err);
            build_exp(cnt);
            apb_write(A_CTRL, 32'd1, err);
            check_frame("frame_random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ws2812_apb_ctrl.md
WS2812_APB_CTRL -- requirements
Module: ws2812_apb_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of pixel buffer entries (1..60).
REQ-002 SHALL have parameter T0H_CYC, default 35, clk_i cycles high for a 0 bit.
REQ-003 SHALL have parameter T1H_CYC, default 70, clk_i cycles high for a 1 bit.
REQ-004 SHALL have parameter TBIT_CYC, default 125, total clk_i cycles per bit (> T1H_CYC > T0H_CYC >= 1).
REQ-005 SHALL have parameter TRST_CYC, default 3000, clk_i cycles of latch-low after a frame.
REQ-006 SHALL have clk_i, input, 1, the only clock.
REQ-007 SHALL have resetn_i, input, 1, reset: asynchronous, active-low.
REQ-008 SHALL have apb_psel_i, apb_penable_i, apb_pwrite_i, each input, 1, APB select/enable/write.
REQ-009 SHALL have apb_paddr_i, input, 8, byte address; apb_pwdata_i, input, 32, write data.
REQ-010 SHALL have apb_prdata_o (output, 32), apb_pready_o (output, 1) and apb_pslverr_o (output, 1), all registered.
REQ-011 SHALL have led_ctl_o, output, 1, WS2812 serial data; debug_o, output, 1, equals BUSY.

Function
REQ-012 Register map SHALL be: 0x00 CTRL (bit0 START, write-1 self-clearing, reads 0); 0x04 STATUS (bit0 BUSY, RO); 0x08 COUNT (bits 5:0, RW); 0x10+4*n PIXEL[n] (bits 23:0 GRB, RW, n < NUM_LEDS).
REQ-013 APB access SHALL complete with one wait state: apb_pready_o high for exactly one cycle, the cycle after psel&penable is first seen, then low for at least one cycle.
REQ-014 Write side effects and read data SHALL be captured in the same cycle apb_pready_o rises.
REQ-015 Any address not in the map, or any address not 4-byte aligned, SHALL set apb_pslverr_o with apb_pready_o, return read data 0 and ignore the write.
REQ-016 A COUNT write above NUM_LEDS SHALL store NUM_LEDS, and the read-back SHALL return the stored value.
REQ-017 Serializer FSM states SHALL be IDLE, LOAD, HIGH, LOW, LATCH.
REQ-018 IDLE -> LOAD on a START write while not busy; a START write while BUSY SHALL be ignored without error.
REQ-019 LOAD SHALL fetch PIXEL[idx] into a 24-bit shift register, then go to HIGH; with COUNT=0, START SHALL go directly to LATCH.
REQ-020 Bits SHALL be sent MSB first (G7..G0, R7..R0, B7..B0); led_ctl_o is high in HIGH for T0H_CYC or T1H_CYC cycles, then low in LOW until TBIT_CYC cycles total.
REQ-021 Consecutive bits and pixels SHALL be gapless: the LOAD cycle is absorbed into the preceding LOW period, giving exactly 24*TBIT_CYC cycles per pixel.
REQ-022 After bit 0 of pixel COUNT-1, the FSM SHALL enter LATCH and hold led_ctl_o low for TRST_CYC cycles, then return to IDLE.
REQ-023 BUSY SHALL be 1 from the cycle after the START write until IDLE is re-entered.
REQ-024 A pixel write during a frame SHALL be accepted; it takes effect in that frame only if that pixel has not yet been loaded.
REQ-025 Bit and latch counters SHALL be sized with $clog2 of their parameter maxima and SHALL NOT wrap.

Reset
REQ-026 On resetn_i low: FSM in IDLE; led_ctl_o=0; BUSY=0; COUNT=NUM_LEDS; PIXEL[*]=0; apb_prdata_o=0; apb_pready_o=0; apb_pslverr_o=0.
REQ-027 Reset mid-frame SHALL force led_ctl_o low asynchronously; no partial bit is completed.

Structure
REQ-028 Package ws2812_pkg SHALL hold the register offsets, the CTRL/STATUS bit positions and the FSM state encoding.
REQ-029 The serializer (FSM, shift register, counters) SHALL be sub-module ws2812_serializer; the APB decode and pixel buffer SHALL stay in the top module.

Verification (NUM_LEDS=4, T0H=2, T1H=4, TBIT=6, TRST=10)
REQ-030 Write PIXEL[0]=0x800001, COUNT=1, START -> 24 bits: first high 4 cycles, 22 highs of 2 cycles, last high 4 cycles; each bit 6 cycles; then 10 cycles low; BUSY falls at 24*6+10 cycles.
REQ-031 Write COUNT=9 -> read COUNT returns 4; read at 0x0C or 0x11 -> pslverr=1, prdata=0.
REQ-032 START during frame -> no restart, no pslverr; frame length unchanged.
REQ-033 COUNT=0, START -> led_ctl_o stays low, BUSY high for 10 cycles (+1 entry cycle).
REQ-034 Assert resetn_i at cycle 50 of a frame -> led_ctl_o=0 immediately; all registers at reset values; new START works.
REQ-035 COUNT=2, write PIXEL[1]=0xFFFFFF during pixel 0 -> pixel 1 sent as 24 one-bits.
